// File: rtl/matvec_requant_stream.sv
// Requantization stage after the mat-vec engine: bias add, rounding shift,
// DW-bit saturation, optional ReLU, with last/done framing per N-element job.
module matvec_requant_stream #(
    parameter int N   = 786,
    parameter int DW  = 16,
    parameter int SHW = 5,
    localparam int CW = $clog2(N + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [SHW-1:0]    shift_i,
    input  logic              relu_en_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2*DW-1:0]   in_data_i,
    input  logic [2*DW-1:0]   in_bias_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DW-1:0]     out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CW-1:0]     sat_count_o
);
    localparam int SW = 2*DW + 1;
    localparam int AW = 2*DW + 2;
    localparam logic signed [AW-1:0] MAXV = (AW'(1) << (DW-1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SHW-1:0]         shift_q;
    logic                   relu_q;
    logic [CW-1:0]          in_cnt_q, out_cnt_q, sat_cnt_q;
    logic                   s1_vld_q;
    logic signed [SW-1:0]   s1_sum_q;
    logic                   out_vld_q;
    logic [DW-1:0]          out_data_q;

    logic en, in_fire, out_fire, last_beat;
    logic signed [AW-1:0]   ext, rnd, shr;
    logic                   sat;
    logic [DW-1:0]          q;

    // One advance signal for both stages: the pipe moves only when the output slot frees.
    assign en         = !out_vld_q || out_ready_i;
    assign in_ready_o = (state_q == RUN) && en && (in_cnt_q < CW'(N));
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_vld_q && out_ready_i;
    assign last_beat  = (out_cnt_q == CW'(N-1));

    assign out_valid_o = out_vld_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_vld_q && last_beat;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign sat_count_o = sat_cnt_q;

    always_comb begin
        ext = {s1_sum_q[SW-1], s1_sum_q};
        rnd = '0;
        if (shift_q != '0) rnd = AW'(1) << (shift_q - SHW'(1));
        shr = (ext + rnd) >>> shift_q;
        sat = 1'b0;
        q   = shr[DW-1:0];
        if (shr > MAXV) begin
            q   = MAXV[DW-1:0];
            sat = 1'b1;
        end else if (shr < MINV) begin
            q   = MINV[DW-1:0];
            sat = 1'b1;
        end
        if (relu_q && q[DW-1]) q = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q   <= 1'b0;
            s1_sum_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (en) begin
            s1_vld_q  <= in_fire;
            if (in_fire)
                s1_sum_q <= {in_data_i[2*DW-1], in_data_i} + {in_bias_i[2*DW-1], in_bias_i};
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) out_data_q <= q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            relu_q    <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            sat_cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            shift_q   <= (int'(shift_i) >= 2*DW) ? SHW'(2*DW-1) : shift_i;
            relu_q    <= relu_en_i;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            if (in_fire)                 in_cnt_q  <= in_cnt_q + CW'(1);
            if (out_fire)                out_cnt_q <= out_cnt_q + CW'(1);
            if (en && s1_vld_q && sat)   sat_cnt_q <= sat_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (in_fire && in_cnt_q == CW'(N-1)) state_d = DRAIN;
            DRAIN:   if (out_fire && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
